// File: rtl/fixed_encoder_ordern_pkg.sv
// ---------------------------------------------------------------------------
// fixed_enc_pkg
// Shared definitions for the order-N fixed residual encoder: the order type,
// the highest supported predictor order, the FLAC fixed-predictor
// coefficient table and small helpers used by the encoder files.
// ---------------------------------------------------------------------------
package fixed_enc_pkg;

  // Predictor order as carried on the bus (0..4 meaningful, 5..7 alias 4).
  typedef logic [2:0] order_t;

  localparam int MAX_ORDER  = 4;
  localparam int NUM_ORDERS = MAX_ORDER + 1;

  // Default sample/residual widths; order-4 coefficients sum to 16 in
  // magnitude, so four extra bits hold every residual exactly.
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RES_W  = DEF_DATA_W + 4;

  // COEF[k][j] multiplies the sample j steps back for order k
  // (j = 0 is the current sample). Rows are binomial coefficients with
  // alternating sign.
  localparam int COEF [0:MAX_ORDER][0:MAX_ORDER] = '{
    '{1,  0,  0,  0, 0},
    '{1, -1,  0,  0, 0},
    '{1, -2,  1,  0, 0},
    '{1, -3,  3, -1, 0},
    '{1, -4,  6, -4, 1}
  };

  // Sign-extend a default-width sample to the default residual width.
  function automatic logic signed [DEF_RES_W-1:0] widen(
    input logic signed [DEF_DATA_W-1:0] s
  );
    return {{(DEF_RES_W-DEF_DATA_W){s[DEF_DATA_W-1]}}, s};
  endfunction

  // Orders above MAX_ORDER behave as MAX_ORDER.
  function automatic order_t clamp_order(input order_t o);
    if (o > order_t'(MAX_ORDER)) return order_t'(MAX_ORDER);
    return o;
  endfunction

endpackage

// File: rtl/fixed_encoder_ordern_if.sv
// ---------------------------------------------------------------------------
// fixed_encoder_ordern_if
// Sample-in / residual-out bundle of the order-N fixed encoder.
//   iEnable, iSample, iBlockStart, iBlockEnd, iOrder : sample side (master drives)
//   oResidual, oValid, oWarmup                       : per-sample residual
//   oBestOrder, oBestSum, oBestValid                 : per-block best order
// master = sample framer side, slave = encoder.
// ---------------------------------------------------------------------------
interface fixed_encoder_ordern_if #(
  parameter int DATA_W  = 16,
  parameter int RES_W   = DATA_W + 4,
  parameter int BLOCK_W = 16,
  parameter int SUM_W   = RES_W + BLOCK_W
);
  import fixed_enc_pkg::*;

  logic                     iEnable;
  logic signed [DATA_W-1:0] iSample;
  logic                     iBlockStart;
  logic                     iBlockEnd;
  order_t                   iOrder;
  logic signed [RES_W-1:0]  oResidual;
  logic                     oValid;
  logic                     oWarmup;
  order_t                   oBestOrder;
  logic [SUM_W-1:0]         oBestSum;
  logic                     oBestValid;

  modport master (
    output iEnable, iSample, iBlockStart, iBlockEnd, iOrder,
    input  oResidual, oValid, oWarmup, oBestOrder, oBestSum, oBestValid
  );

  modport slave (
    input  iEnable, iSample, iBlockStart, iBlockEnd, iOrder,
    output oResidual, oValid, oWarmup, oBestOrder, oBestSum, oBestValid
  );

endinterface

// File: rtl/fixed_encoder_ordern_abs_accum.sv
// ---------------------------------------------------------------------------
// fixed_abs_accum
// One saturating accumulator of |value|.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : discard the running sum before this cycle's update
//   en         : add |value| this cycle
//   value      : signed residual (most negative code never occurs)
//   sum_next   : the sum as it will be after this edge, so the caller can
//                compare final sums on the same cycle as the last sample
// ---------------------------------------------------------------------------
module fixed_abs_accum #(
  parameter int RES_W = 20,
  parameter int SUM_W = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [RES_W-1:0] value,
  output logic [SUM_W-1:0]        sum_next
);

  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;
  logic [SUM_W-1:0] base;
  logic [RES_W-1:0] mag;
  logic [SUM_W:0]   wide;

  // Clear takes effect before the add, so a clearing sample can still count.
  // The extra carry bit of 'wide' detects overflow for saturation.
  always_comb begin
    mag   = value[RES_W-1] ? $unsigned(-value) : $unsigned(value);
    base  = clr ? '0 : sum_q;
    wide  = {1'b0, base} + (SUM_W+1)'(mag);
    sum_d = base;
    if (en) begin
      sum_d = wide[SUM_W] ? '1 : wide[SUM_W-1:0];
    end
  end

  assign sum_next = sum_d;

  // Running sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/fixed_encoder_ordern.sv
// ---------------------------------------------------------------------------
// fixed_encoder_ordern
// FLAC fixed-predictor residual encoder, orders 0..4 computed in parallel.
// Emits the residual of the per-sample selected order (or the verbatim
// sample while the block is still warming up) and, at block end, reports
// the order whose absolute residual sum over samples n >= 4 is smallest.
//   iClock : rising-edge clock
//   iReset : asynchronous active-low reset
//   enc    : sample/residual/best-order bundle (slave side)
// ---------------------------------------------------------------------------
module fixed_encoder_ordern
  import fixed_enc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RES_W   = DATA_W + 4,
  parameter int BLOCK_W = 16,
  parameter int SUM_W   = RES_W + BLOCK_W
) (
  input  logic                  iClock,
  input  logic                  iReset,
  fixed_encoder_ordern_if.slave enc
);

  logic signed [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
  logic [2:0]               n_q, n_d;
  logic signed [RES_W-1:0]  residual_q, residual_d;
  logic                     valid_q, valid_d;
  logic                     warmup_q, warmup_d;
  order_t                   best_order_q, best_order_d;
  logic [SUM_W-1:0]         best_sum_q, best_sum_d;
  logic                     best_valid_q, best_valid_d;

  logic signed [RES_W-1:0]  taps [0:MAX_ORDER];
  logic signed [RES_W-1:0]  res  [0:MAX_ORDER];
  logic [SUM_W-1:0]         sum_next [0:MAX_ORDER];
  logic [2:0]               n_eff;
  order_t                   sel;
  logic                     acc_clr;
  logic                     acc_en;
  order_t                   min_order;
  logic [SUM_W-1:0]         min_sum;

  // A block start wipes the history and sample index before this sample is
  // used, so taps and n_eff already reflect the cleared state. All five
  // residuals are formed from the coefficient table at full residual width.
  always_comb begin
    taps[0] = RES_W'(enc.iSample);
    taps[1] = enc.iBlockStart ? '0 : RES_W'(x1_q);
    taps[2] = enc.iBlockStart ? '0 : RES_W'(x2_q);
    taps[3] = enc.iBlockStart ? '0 : RES_W'(x3_q);
    taps[4] = enc.iBlockStart ? '0 : RES_W'(x4_q);
    n_eff   = enc.iBlockStart ? 3'd0 : n_q;
    sel     = clamp_order(enc.iOrder);
    for (int k = 0; k <= MAX_ORDER; k++) begin
      res[k] = '0;
      for (int j = 0; j <= MAX_ORDER; j++) begin
        res[k] = res[k] + RES_W'(COEF[k][j]) * taps[j];
      end
    end
  end

  // Every order accumulates over the same samples: n >= 4 only.
  assign acc_clr = enc.iEnable & enc.iBlockStart;
  assign acc_en  = enc.iEnable & (n_eff == 3'(MAX_ORDER));

  genvar g;
  generate
    for (g = 0; g <= MAX_ORDER; g++) begin : g_acc
      fixed_abs_accum #(
        .RES_W (RES_W),
        .SUM_W (SUM_W)
      ) u_acc (
        .clk      (iClock),
        .rst_n    (iReset),
        .clr      (acc_clr),
        .en       (acc_en),
        .value    (res[g]),
        .sum_next (sum_next[g])
      );
    end
  endgenerate

  // Priority compare over the post-update sums; strict '<' keeps the lower
  // order on ties. The result is only captured on a block-end sample.
  always_comb begin
    min_order = '0;
    min_sum   = sum_next[0];
    for (int k = 1; k <= MAX_ORDER; k++) begin
      if (sum_next[k] < min_sum) begin
        min_order = order_t'(k);
        min_sum   = sum_next[k];
      end
    end
  end

  // Next-state logic. Without iEnable nothing advances, the residual and
  // best-order results hold, and both valid strobes drop.
  always_comb begin
    x1_d         = x1_q;
    x2_d         = x2_q;
    x3_d         = x3_q;
    x4_d         = x4_q;
    n_d          = n_q;
    residual_d   = residual_q;
    valid_d      = 1'b0;
    warmup_d     = warmup_q;
    best_order_d = best_order_q;
    best_sum_d   = best_sum_q;
    best_valid_d = 1'b0;
    if (enc.iEnable) begin
      x1_d    = enc.iSample;
      x2_d    = enc.iBlockStart ? '0 : x1_q;
      x3_d    = enc.iBlockStart ? '0 : x2_q;
      x4_d    = enc.iBlockStart ? '0 : x3_q;
      n_d     = (n_eff == 3'(MAX_ORDER)) ? n_eff : n_eff + 3'd1;
      valid_d = 1'b1;
      if (n_eff < sel) begin
        residual_d = taps[0];
        warmup_d   = 1'b1;
      end else begin
        residual_d = res[sel];
        warmup_d   = 1'b0;
      end
      if (enc.iBlockEnd) begin
        best_order_d = min_order;
        best_sum_d   = min_sum;
        best_valid_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      x1_q         <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      x4_q         <= '0;
      n_q          <= '0;
      residual_q   <= '0;
      valid_q      <= 1'b0;
      warmup_q     <= 1'b0;
      best_order_q <= '0;
      best_sum_q   <= '0;
      best_valid_q <= 1'b0;
    end else begin
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      x3_q         <= x3_d;
      x4_q         <= x4_d;
      n_q          <= n_d;
      residual_q   <= residual_d;
      valid_q      <= valid_d;
      warmup_q     <= warmup_d;
      best_order_q <= best_order_d;
      best_sum_q   <= best_sum_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign enc.oResidual  = residual_q;
  assign enc.oValid     = valid_q;
  assign enc.oWarmup    = warmup_q;
  assign enc.oBestOrder = best_order_q;
  assign enc.oBestSum   = best_sum_q;
  assign enc.oBestValid = best_valid_q;

endmodule

// File: tb/tb_fixed_encoder_ordern.sv
// ---------------------------------------------------------------------------
// tb_fixed_encoder_ordern
// Directed bench for fixed_encoder_ordern. A block-level model keeps the
// samples of the current block and derives each order-k residual as the
// k-th backward difference; the DUT is compared to it every cycle, and
// hand-computed literals pin both the model and the DUT at key samples.
// ---------------------------------------------------------------------------
module tb_fixed_encoder_ordern;

  localparam int DATA_W  = 16;
  localparam int RES_W   = 20;
  localparam int BLOCK_W = 16;
  localparam int SUM_W   = 36;
  localparam longint SUM_MAX = (longint'(1) << SUM_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  fixed_encoder_ordern_if #(
    .DATA_W (DATA_W), .RES_W (RES_W), .BLOCK_W (BLOCK_W), .SUM_W (SUM_W)
  ) enc_if ();

  fixed_encoder_ordern #(
    .DATA_W (DATA_W), .RES_W (RES_W), .BLOCK_W (BLOCK_W), .SUM_W (SUM_W)
  ) dut (
    .iClock (clk),
    .iReset (rst_n),
    .enc    (enc_if)
  );

  always #5 clk = ~clk;

  int  n_vec  = 0;
  int  n_fail = 0;
  bit  chk_on = 1'b0;

  // Model state: samples of the current block and the five running sums.
  longint blk[$];
  longint sums[5];
  longint exp_res;
  bit     exp_valid, exp_warm, exp_bv;
  int     exp_bo;
  longint exp_bs;

  task automatic compareVal(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // k-th backward difference ending at x; samples before the block are 0.
  function automatic longint kthDiff(input int k, input longint x);
    longint v[5];
    int n = blk.size();
    for (int j = 0; j <= k; j++) begin
      int idx = n - k + j;
      if (j == k) v[j] = x;
      else        v[j] = (idx >= 0) ? blk[idx] : 0;
    end
    for (int p = 1; p <= k; p++)
      for (int i = k; i >= p; i--)
        v[i] = v[i] - v[i-1];
    return v[k];
  endfunction

  task automatic modelReset();
    blk.delete();
    foreach (sums[i]) sums[i] = 0;
    exp_res = 0; exp_valid = 0; exp_warm = 0;
    exp_bo = 0; exp_bs = 0; exp_bv = 0;
  endtask

  task automatic modelStep(input longint s, input bit st, input bit ed, input int ord);
    int k = (ord > 4) ? 4 : ord;
    int n;
    longint d;
    if (st) begin
      blk.delete();
      foreach (sums[i]) sums[i] = 0;
    end
    n = blk.size();
    if (n < k) begin
      exp_res  = s;
      exp_warm = 1;
    end else begin
      exp_res  = kthDiff(k, s);
      exp_warm = 0;
    end
    if (n >= 4) begin
      for (int o = 0; o < 5; o++) begin
        d = kthDiff(o, s);
        if (d < 0) d = -d;
        sums[o] = (sums[o] + d > SUM_MAX) ? SUM_MAX : sums[o] + d;
      end
    end
    blk.push_back(s);
    exp_valid = 1;
    exp_bv    = 0;
    if (ed) begin
      exp_bo = 0;
      exp_bs = sums[0];
      for (int o = 1; o < 5; o++) begin
        if (sums[o] < exp_bs) begin
          exp_bo = o;
          exp_bs = sums[o];
        end
      end
      exp_bv = 1;
    end
  endtask

  // Drive one cycle of inputs and advance the model at the consuming edge.
  task automatic applyStimulus(input bit en, input longint s, input bit st,
                               input bit ed, input int ord);
    @(negedge clk);
    #1;
    enc_if.iEnable     = en;
    enc_if.iSample     = DATA_W'(s);
    enc_if.iBlockStart = st;
    enc_if.iBlockEnd   = ed;
    enc_if.iOrder      = 3'(ord);
    @(posedge clk);
    #1;
    if (en) begin
      modelStep(s, st, ed, ord);
    end else begin
      exp_valid = 0;
      exp_bv    = 0;
    end
  endtask

  // Literal residual check right after the consuming edge.
  task automatic checkOutput(input string name, input longint req_res, input bit req_w);
    compareVal({name, " model residual"}, exp_res, req_res);
    compareVal({name, " oResidual"}, longint'($signed(enc_if.oResidual)), req_res);
    compareVal({name, " oWarmup"}, longint'(enc_if.oWarmup), longint'(req_w));
  endtask

  // Literal best-order check right after the block-end edge.
  task automatic checkBest(input string name, input int req_o, input longint req_s);
    compareVal({name, " model best order"}, exp_bo, req_o);
    compareVal({name, " model best sum"}, exp_bs, req_s);
    compareVal({name, " oBestOrder"}, longint'(enc_if.oBestOrder), req_o);
    compareVal({name, " oBestSum"}, longint'(enc_if.oBestSum), req_s);
    compareVal({name, " oBestValid"}, longint'(enc_if.oBestValid), 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    enc_if.iEnable = 1'b0;
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      compareVal("oValid", longint'(enc_if.oValid), longint'(exp_valid));
      compareVal("oBestValid", longint'(enc_if.oBestValid), longint'(exp_bv));
      compareVal("oResidual", longint'($signed(enc_if.oResidual)), exp_res);
      compareVal("oWarmup", longint'(enc_if.oWarmup), longint'(exp_warm));
      compareVal("oBestOrder", longint'(enc_if.oBestOrder), exp_bo);
      compareVal("oBestSum", longint'(enc_if.oBestSum), exp_bs);
    end
  end

  int     blk_a [10] = '{20, 10, -7, -4, 8, 0, 2, -3, 1, 0};
  int     a_o1  [10] = '{20, -10, -17, 3, 12, -8, 2, -5, 4, -1};
  int     a_o2  [10] = '{20, 10, -7, 20, 9, -20, 10, -7, 9, -5};
  longint smp;

  initial begin
    rst_n              = 1'b1;
    enc_if.iEnable     = 1'b0;
    enc_if.iSample     = '0;
    enc_if.iBlockStart = 1'b0;
    enc_if.iBlockEnd   = 1'b0;
    enc_if.iOrder      = '0;
    modelReset();
    #1 rst_n = 1'b0;
    #2 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] block A, order 1");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, blk_a[i], i == 0, i == 9, 1);
      checkOutput($sformatf("A1[%0d]", i), a_o1[i], i < 1);
    end
    checkBest("A1", 0, 14);

    $display("[TB] block A, order 2, back-to-back");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, blk_a[i], i == 0, i == 9, 2);
      checkOutput($sformatf("A2[%0d]", i), a_o2[i], i < 2);
    end
    checkBest("A2", 0, 14);

    // Start/end strobes without iEnable must be ignored.
    applyStimulus(0, 999, 1, 1, 0);
    applyStimulus(0, 999, 1, 1, 0);

    $display("[TB] constant block");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 100, i == 0, i == 9, 0);
      if (i == 0) checkOutput("CONST[0]", 100, 0);
    end
    checkBest("CONST", 1, 0);

    $display("[TB] ramp, order 7 treated as 4");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 3 * i, i == 0, i == 9, 7);
      if (i == 3) checkOutput("RAMP[3]", 9, 1);
      if (i == 4) checkOutput("RAMP[4]", 0, 0);
      if (i == 9) checkOutput("RAMP[9]", 0, 0);
    end
    checkBest("RAMP", 2, 0);

    $display("[TB] full-scale alternation, order 4");
    for (int i = 0; i < 10; i++) begin
      smp = (i % 2 == 0) ? 32767 : -32768;
      applyStimulus(1, smp, i == 0, i == 9, 4);
      if (i == 4) checkOutput("ALT[4]", 524280, 0);
      if (i == 5) checkOutput("ALT[5]", -524280, 0);
    end
    checkBest("ALT", 0, 196605);

    applyStimulus(1, 500, 1, 1, 3);
    checkOutput("SINGLE", 500, 1);
    checkBest("SINGLE", 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] reset mid-block, gaps, back-to-back");
    applyStimulus(1, 30, 1, 0, 0);
    applyStimulus(1, 31, 0, 0, 0);
    applyStimulus(1, 32, 0, 0, 0);
    doReset();
    applyStimulus(1, 50, 0, 0, 1);
    checkOutput("POSTRST[0]", 50, 1);
    applyStimulus(1, 60, 0, 0, 1);
    checkOutput("POSTRST[1]", 10, 0);
    applyStimulus(0, 7, 0, 1, 2);
    applyStimulus(1, 75, 0, 0, 2);
    checkOutput("POSTRST[2]", 5, 0);
    applyStimulus(0, 7, 1, 0, 2);
    applyStimulus(1, 80, 0, 0, 0);
    applyStimulus(1, 85, 0, 0, 0);
    applyStimulus(1, 90, 0, 1, 0);
    checkBest("POSTRST", 2, 0);
    applyStimulus(1, -5, 1, 0, 1);
    checkOutput("SHORT[0]", -5, 1);
    applyStimulus(1, -2, 0, 0, 1);
    checkOutput("SHORT[1]", 3, 0);
    applyStimulus(1, -1, 0, 1, 1);
    checkBest("SHORT", 0, 0);

    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
